display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Parametrised multiplexed 7-segment display scanner for the ALU result display. It drives the shared digit bus and active-low anodes for NUM_DIGITS digits, cycling through them at a programmable refresh rate. It adds frame-synchronous double-buffered loading, per-digit blanking, leading-zero suppression and per-digit blink, none of which the fixed 4:1 digit selector provides. It sits between the binary-to-BCD converter (upstream) and the segment decoder and anode pins (downstream).

## Interface
Parameters:
- NUM_DIGITS, 4: number of display digits; must be ≥ 2.
- DIGIT_W, 4: width of each digit code in bits.
- REFRESH_DIV, 100000: clock cycles per digit slot; must be ≥ 2.
- BLINK_DIV, 64: scan frames per blink half-period; must be ≥ 1.

Ports, where SW = max(1, $clog2(NUM_DIGITS)):
- clk  in  1  system clock; single clock domain, all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable.
- load  in  1  single-cycle request to capture digits_in.
- digits_in  in  NUM_DIGITS*DIGIT_W  digit codes; digit 0 (ones) occupies bits [DIGIT_W-1:0].
- blank_mask  in  NUM_DIGITS  forces the corresponding digit dark; sampled live.
- blink_mask  in  NUM_DIGITS  makes the corresponding digit blink; sampled live.
- lz_suppress  in  1  enables leading-zero suppression; sampled live.
- digit_BCD  out  DIGIT_W  code of the digit currently lit.
- AN  out  NUM_DIGITS  anode enables, active-low, one-hot-low.
- AN_SEL  out  SW  index of the current scan slot.
- frame_tick  out  1  one-cycle pulse at each frame start.
- busy  out  1  a captured load is pending and not yet displayed.

## Operation
- **Prescaler.**
  - The prescaler counts 0..REFRESH_DIV-1 while en=1 and holds while en=0.
  - Its terminal count produces slot_tick.
- **Scan index.**
  - On slot_tick the scan index increments, wrapping from NUM_DIGITS-1 to 0.
  - The wrap produces frame_tick.
- **Double buffer.**
  - load=1 copies digits_in into the pending register and sets busy.
  - On frame_tick with busy=1, the active register takes the pending register and busy clears.
  - load while busy overwrites the pending register; the last load wins.
  - If load and frame_tick occur in the same cycle, the old pending value moves to active, the new digits_in goes to pending, and busy stays 1.
- **Leading-zero suppression** (lz_suppress=1):
  - Digit i (i ≥ 1) is suppressed when active digit i and every higher digit are 0.
  - Digit 0 is never suppressed.
- **Blink.**
  - A frame counter toggles blink_phase every BLINK_DIV frame_ticks.
  - While blink_phase=1, digits with blink_mask=1 are dark.
- **Dark digit** (blanked, suppressed, or blinked off): during its slot AN is all ones and digit_BCD = 0.
- **Lit digit:** AN bit [index] = 0, all other AN bits = 1, digit_BCD = active digit[index].
- **Disable (en=0):**
  - AN is forced all ones.
  - Index, prescaler and blink state hold.
  - load is still accepted.
  - Scanning resumes from the held state when en returns to 1.

## Timing
- **Reset:** prescaler=0, index=0, AN=all ones, AN_SEL=0, digit_BCD=0, frame_tick=0, busy=0, active register=0, pending register=0, blink_phase=0, blink counter=0.
- **Registered outputs:** AN, AN_SEL and digit_BCD are registered. They reflect the new index one cycle after slot_tick.
- **frame_tick:** asserts in the cycle after the wrapping slot_tick, coincident with the AN_SEL=0 output update. The first frame_tick after reset occurs NUM_DIGITS*REFRESH_DIV cycles after reset release with en=1.
- **Load latency:** busy rises the cycle after load. New data is visible from the digit-0 slot of the next frame.
- **Mask/flag changes:** changes to blank_mask, blink_mask and lz_suppress take effect at the next output register update.
- **Reset mid-frame:** all state clears immediately, asynchronously. A pending load is discarded.

## Test plan
Bench parameters for all scenarios: NUM_DIGITS=4, DIGIT_W=4, REFRESH_DIV=4, BLINK_DIV=2.
- **Reset/scan:**
  - Stimulus: hold rst_n=0, then release with en=1.
  - Required: AN=1111 and digit_BCD=0 during reset.
  - Required: AN_SEL then steps 0,1,2,3,0 every 4 cycles.
  - Required: frame_tick pulses once per 16 cycles.
- **Load/double buffer:**
  - Stimulus: load digits_in=16'hA593 mid-frame.
  - Required: busy=1 and the old digits keep showing until wrap.
  - Required: the next frame shows 3,9,5,A on AN=1110,1101,1011,0111; busy clears at frame_tick.
- **Simultaneous load and wrap:**
  - Stimulus: pending=16'h1234, then load 16'h5678 on the frame_tick cycle.
  - Required: the frame shows 4,3,2,1 and busy stays 1.
  - Required: the following frame shows 8,7,6,5.
- **Leading-zero suppression:**
  - Stimulus: load 16'h0070 with lz_suppress=1.
  - Required: slots 3 and 2 have AN=1111; slot 1 shows 7; slot 0 shows 0.
  - Stimulus: load 16'h0000.
  - Required: only slot 0 is lit, showing 0.
- **Blink/blank:**
  - Stimulus: blink_mask=4'b0001 and blank_mask=4'b1000.
  - Required: digit 3 is always dark.
  - Required: digit 0 alternates lit/dark every 2 frames.
- **Disable:**
  - Stimulus: drop en at AN_SEL=2 for 10 cycles.
  - Required: AN=1111 and AN_SEL holds at 2.
  - Required: on resume, slot 2 completes its remaining prescaler count before stepping to 3.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scanner: double-buffered digits,
// per-digit blank/blink and leading-zero suppression.
module display_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_W     = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 64,
  localparam int SW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  input  logic                          lz_suppress,
  output logic [DIGIT_W-1:0]            digit_BCD,
  output logic [NUM_DIGITS-1:0]         AN,
  output logic [SW-1:0]                 AN_SEL,
  output logic                          frame_tick,
  output logic                          busy
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int BW =
    (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST =
    PW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] IDX_LAST =
    SW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST =
    BW'(BLINK_DIV - 1);

  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

  logic [PW-1:0] presc_q;
  logic [SW-1:0] idx_q;
  logic [SW-1:0] idx_next;
  logic [BW-1:0] bcnt_q;
  logic          phase_q;
  logic          phase_next;
  digits_t       active_q;
  digits_t       pending_q;
  digits_t       active_next;
  logic          slot_tick;
  logic          wrap;
  logic          swap;

  logic [NUM_DIGITS-1:0] sup;
  logic [NUM_DIGITS-1:0] an_lit;
  logic                  dark;

  assign slot_tick = en && (presc_q == PRESC_LAST);
  assign wrap      = slot_tick && (idx_q == IDX_LAST);
  assign swap      = frame_tick && busy;

  always_comb begin
    idx_next = idx_q;
    if (slot_tick) begin
      if (idx_q == IDX_LAST) idx_next = '0;
      else                   idx_next = idx_q + 1'b1;
    end
  end

  assign phase_next =
    (wrap && (bcnt_q == BLINK_LAST)) ? ~phase_q
                                     : phase_q;

  assign active_next = swap ? pending_q : active_q;

  // A digit is suppressed when it and all higher
  // digits are zero; the ones digit always shows.
  always_comb begin
    logic z;
    z   = 1'b1;
    sup = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z      = z && (active_next[i] == '0);
      sup[i] = lz_suppress && z && (i != 0);
    end
  end

  always_comb begin
    an_lit = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_next == SW'(i)) an_lit[i] = 1'b0;
    end
  end

  assign dark = blank_mask[idx_next]
              | (blink_mask[idx_next] & phase_next)
              | sup[idx_next];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (en) begin
      presc_q <= slot_tick ? '0 : presc_q + 1'b1;
      idx_q   <= idx_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else if (wrap) begin
      bcnt_q  <= (bcnt_q == BLINK_LAST) ? '0
                                        : bcnt_q + 1'b1;
      phase_q <= phase_next;
    end
  end

  // Pending moves to active one cycle after the wrap;
  // a load in that same cycle refills pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_tick <= 1'b0;
      active_q   <= '0;
      pending_q  <= '0;
      busy       <= 1'b0;
    end else begin
      frame_tick <= wrap;
      active_q   <= active_next;
      if (load) pending_q <= digits_in;
      busy <= load | (busy & ~swap);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      AN        <= '1;
      AN_SEL    <= '0;
      digit_BCD <= '0;
    end else begin
      AN_SEL <= idx_next;
      if (!en || dark) begin
        AN        <= '1;
        digit_BCD <= '0;
      end else begin
        AN        <= an_lit;
        digit_BCD <= active_next[idx_next];
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: arithmetic model of the
// scan timeline plus hand-computed directed checks.
module tb_display_scan_ctrl;

  localparam int N = 4;
  localparam int W = 4;
  localparam int R = 4;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic        lz_suppress;
  logic [3:0]  digit_BCD;
  logic [3:0]  AN;
  logic [1:0]  AN_SEL;
  logic        frame_tick;
  logic        busy;

  display_scan_ctrl #(
    .NUM_DIGITS (N),
    .DIGIT_W    (W),
    .REFRESH_DIV(R),
    .BLINK_DIV  (B)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .digits_in  (digits_in),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .lz_suppress(lz_suppress),
    .digit_BCD  (digit_BCD),
    .AN         (AN),
    .AN_SEL     (AN_SEL),
    .frame_tick (frame_tick),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit run = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Model: n counts enabled clock edges since reset;
  // slot, frame and blink phase follow by division.
  int          m_n;
  bit          m_ft;
  bit          m_busy;
  logic [15:0] m_active;
  logic [15:0] m_pending;
  logic [3:0]  m_an;
  logic [3:0]  m_bcd;
  logic [1:0]  m_sel;

  task automatic model_reset();
    m_n = 0; m_ft = 0; m_busy = 0;
    m_active = 0; m_pending = 0;
    m_an = 4'hF; m_bcd = 0; m_sel = 0;
  endtask

  task automatic model_step();
    bit          ft_old;
    int          sel;
    bit          ph;
    bit          dark;
    logic [15:0] upper;
    ft_old = m_ft;
    if (en) m_n++;
    m_ft = en && (m_n % (N * R) == 0);
    if (ft_old && m_busy) begin
      m_active = m_pending;
      m_busy   = 0;
    end
    if (load) begin
      m_pending = digits_in;
      m_busy    = 1;
    end
    sel   = (m_n / R) % N;
    ph    = ((m_n / (N * R)) / B) % 2;
    upper = m_active >> (W * sel);
    dark  = blank_mask[sel]
         || (blink_mask[sel] && ph)
         || (lz_suppress && sel != 0 && upper == 0);
    m_sel = 2'(sel);
    if (!en || dark) begin
      m_an  = 4'hF;
      m_bcd = 4'h0;
    end else begin
      m_an  = ~(4'b0001 << sel);
      m_bcd = upper[3:0];
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("an",    AN,         m_an);
      chk("sel",   AN_SEL,     m_sel);
      chk("bcd",   digit_BCD,  m_bcd);
      chk("ftick", frame_tick, m_ft);
      chk("busy",  busy,       m_busy);
    end
  end

  task automatic step(input int k = 1);
    repeat (k) @(negedge clk);
    #1;
  endtask

  task automatic wait_frame();
    int c = 0;
    do begin
      step();
      c++;
    end while (!frame_tick && c < 40);
    chk("wait_frame", frame_tick, 1);
  endtask

  task automatic wait_sel(input logic [1:0] s);
    int c = 0;
    do begin
      step();
      c++;
    end while (AN_SEL != s && c < 40);
    chk("wait_sel", AN_SEL, s);
  endtask

  task automatic show(input string nm,
                      input logic [1:0] s,
                      input logic [3:0] an,
                      input logic [3:0] d);
    chk({nm, "_sel"}, AN_SEL,    s);
    chk({nm, "_an"},  AN,        an);
    chk({nm, "_bcd"}, digit_BCD, d);
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    digits_in = v;
    step();
    load = 1'b0;
  endtask

  int  ft_cnt;
  bit  lit_exp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0;
    digits_in = '0; blank_mask = '0;
    blink_mask = '0; lz_suppress = 1'b0;
    step(3);
    run = 1'b1;
    chk("rst_an",   AN,        4'hF);
    chk("rst_bcd",  digit_BCD, 4'h0);
    chk("rst_busy", busy,      1'b0);

    en = 1'b1;
    rst_n = 1'b1;
    ft_cnt = 0;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (frame_tick) ft_cnt++;
      if (k % 4 == 1)
        chk("scan_sel", AN_SEL, ((k - 1) / 4) % 4);
      if (k == 15) chk("ft_early", frame_tick, 0);
      if (k == 16) chk("ft_first", frame_tick, 1);
    end
    chk("ft_count", ft_cnt, 2);

    step(5);
    chk("mid_sel", AN_SEL, 1);
    do_load(16'hA593);
    chk("ld_busy", busy, 1);
    step(4);
    chk("ld_old", digit_BCD, 0);
    wait_frame();
    chk("ld_busy_ft", busy, 1);
    step();    show("ld0", 0, 4'hE, 4'h3);
    chk("ld_clr", busy, 0);
    step(4);   show("ld1", 1, 4'hD, 4'h9);
    step(4);   show("ld2", 2, 4'hB, 4'h5);
    step(4);   show("ld3", 3, 4'h7, 4'hA);

    wait_frame();
    do_load(16'h1234);
    wait_frame();
    do_load(16'h5678);
    show("sim0", 0, 4'hE, 4'h4);
    chk("sim_busy", busy, 1);
    step(4);   show("sim1", 1, 4'hD, 4'h3);
    step(4);   show("sim2", 2, 4'hB, 4'h2);
    step(4);   show("sim3", 3, 4'h7, 4'h1);
    wait_frame();
    step();    show("nxt0", 0, 4'hE, 4'h8);
    chk("nxt_busy", busy, 0);
    step(4);   show("nxt1", 1, 4'hD, 4'h7);
    step(4);   show("nxt2", 2, 4'hB, 4'h6);
    step(4);   show("nxt3", 3, 4'h7, 4'h5);

    lz_suppress = 1'b1;
    do_load(16'h0070);
    wait_frame();
    step();    show("lz0", 0, 4'hE, 4'h0);
    step(4);   show("lz1", 1, 4'hD, 4'h7);
    step(4);   show("lz2", 2, 4'hF, 4'h0);
    step(4);   show("lz3", 3, 4'hF, 4'h0);
    do_load(16'h0000);
    wait_frame();
    step();    show("lzz0", 0, 4'hE, 4'h0);
    step(4);   show("lzz1", 1, 4'hF, 4'h0);

    lz_suppress = 1'b0;
    blank_mask = 4'b1000;
    blink_mask = 4'b0001;
    do_load(16'h1234);
    wait_frame();
    for (int f = 0; f < 4; f++) begin
      step();
      if (lit_exp[f]) show("blk_on",  0, 4'hE, 4'h4);
      else            show("blk_off", 0, 4'hF, 4'h0);
      step(12);
      show("blank3", 3, 4'hF, 4'h0);
      wait_frame();
    end

    blank_mask = '0;
    blink_mask = '0;
    wait_sel(2);
    step();
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("dis_an",  AN,     4'hF);
      chk("dis_sel", AN_SEL, 2);
    end
    en = 1'b1;
    step();    chk("res_sel_a", AN_SEL, 2);
    step();    chk("res_sel_b", AN_SEL, 2);
    step();    chk("res_sel_c", AN_SEL, 3);

    do_load(16'h9999);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy,      0);
    chk("arst_an",   AN,        4'hF);
    chk("arst_bcd",  digit_BCD, 4'h0);
    step(2);
    rst_n = 1'b1;
    step(2);
    show("post_rst", 0, 4'hE, 4'h0);
    chk("post_busy", busy, 0);

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
